serial_rx: RTL

- 8N1-style serial receiver: the input side of a single-wire serial link.
- Takes an asynchronous line input, synchronises it, and detects the start bit.
- Samples each bit at mid-bit and delivers a parallel byte with a one-cycle valid strobe.
- Used by the basics designs that need data from a serial line or host.

---
 rtl/serial_rx.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/serial_rx.sv
// serial_rx: 8N1-style serial receiver with a 2-flop input synchroniser and mid-bit sampling.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module serial_rx #(
    parameter int CLKS_PER_BIT = 16,  // even, >= 4
    parameter int DATA_BITS    = 8    // 5..9, sent LSB first
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_busy,
    output logic                 frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif

    state_t               state;
    state_t               state_next;
    logic                 sync_ff;
    logic                 rx_s;
    logic [CNT_W-1:0]     clk_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 cnt_mid;
    logic                 cnt_last;
    logic                 idx_last;
    logic                 cnt_clear;
    logic                 data_sample;
    logic                 stop_sample;
    logic                 frame_ok;
    logic                 valid_next;
    logic                 err_next;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_bit;
    logic                 par_sample;
`endif

    // NOTE: clocked blocks use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            sync_ff <= rx_in;
            rx_s    <= sync_ff;
        end
    end

    assign cnt_mid  = (clk_cnt == CNT_MID);
    assign cnt_last = (clk_cnt == CNT_LAST);
    assign idx_last = (bit_idx == IDX_LAST);

    // State register, bit timing counters and registered output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            rx_valid  <= valid_next;
            frame_err <= err_next;
            if (valid_next) begin
                rx_data <= shift_reg;
            end
            if (cnt_clear) begin
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (state != DATA) begin
                bit_idx <= '0;
            end else if (cnt_last) begin
                bit_idx <= idx_last ? '0 : bit_idx + 1'b1;
            end
        end
    end

    // NOTE: the data path carries no reset; every bit is rewritten before a frame can load rx_data.
    always_ff @(posedge clk) begin
        if (data_sample) begin
            shift_reg[bit_idx] <= rx_s;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (par_sample) begin
            par_bit <= rx_s;
        end
    end
`endif

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (!rx_s) state_next = START;
            end
            START: begin
                // A line that is high again at mid start bit was a glitch.
                if (cnt_mid) state_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
`ifdef SERIAL_RX_PARITY_EN
                if (cnt_last && idx_last) state_next = PARITY;
`else
                if (cnt_last && idx_last) state_next = STOP;
`endif
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (cnt_last) state_next = STOP;
            end
`endif
            STOP: begin
                if (cnt_last) state_next = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                // A held-low break line waits here rather than re-triggering frames.
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_busy     = (state != IDLE);
        data_sample = (state == DATA) && cnt_last;
        stop_sample = (state == STOP) && cnt_last;
        cnt_clear   = (state_next != state) || cnt_last ||
                      (state == IDLE) || (state == WAIT_HIGH);
`ifdef SERIAL_RX_PARITY_EN
        par_sample  = (state == PARITY) && cnt_last;
        frame_ok    = rx_s && ((^shift_reg) == par_bit);
`else
        frame_ok    = rx_s;
`endif
        valid_next  = stop_sample && frame_ok;
        err_next    = stop_sample && !frame_ok;
    end

endmodule
